// File: rtl/vector_list_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vector_list_sequencer_if                                                  |
// | Display-list memory read port plus the jump/draw/ready handshake to the   |
// | vector beam controller.                                                   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface vector_list_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] mem_addr;
  logic [25:0]       mem_data;
  logic [11:0]       x;
  logic [11:0]       y;
  logic              jump;
  logic              draw;
  logic              ctrl_ready;
  logic              beam_on;

  // Sequencer side
  modport master (
    output mem_addr, x, y, jump, draw, beam_on,
    input  mem_data, ctrl_ready
  );

  // Memory / controller side
  modport slave (
    input  mem_addr, x, y, jump, draw, beam_on,
    output mem_data, ctrl_ready
  );
endinterface
`default_nettype wire

// File: rtl/vector_list_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vector_list_sequencer                                                     |
// | Fetches jump/draw/NOP/EOF commands from a synchronous-read display list   |
// | and plays them into the vector controller with handshake, guard cycles,   |
// | optional post-jump settling, frame looping and beam blanking.             |
// | Optional feature macro: VECSEQ_DWELL_EN (adds the SETTLE state).          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module vector_list_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DWELL  = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic stop,
  input  logic loop,
  output logic busy,
  output logic frame_done,
  vector_list_sequencer_if.master bus
);

  localparam logic [1:0]        OP_JUMP   = 2'b00;
  localparam logic [1:0]        OP_DRAW   = 2'b01;
  localparam logic [1:0]        OP_EOF    = 2'b10;
  localparam logic [1:0]        OP_NOP    = 2'b11;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  // Settle length must fit the 8-bit dwell counter
  if (DWELL < 1 || DWELL > 255) begin : g_dwell_range
    $error("vector_list_sequencer: DWELL must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WAIT_RDY,
    S_ISSUE,
    S_GUARD,
    S_WAIT_DONE
`ifdef VECSEQ_DWELL_EN
    , S_SETTLE
`endif
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_next;
  logic [1:0]        opcode;
  logic              op_draw;
  logic [11:0]       x_lat;
  logic [11:0]       y_lat;
  logic [11:0]       x_q;
  logic [11:0]       y_q;
  logic              guard_cnt;
  logic              latch_cmd;
  logic              load_xy;

  assign opcode = bus.mem_data[25:24];

`ifdef VECSEQ_DWELL_EN
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  logic [7:0] dwell_cnt;

  // Counts blanked settle cycles while in SETTLE, cleared elsewhere
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dwell_cnt <= 8'd0;
    end else if (state == S_SETTLE) begin
      dwell_cnt <= dwell_cnt + 8'd1;
    end else begin
      dwell_cnt <= 8'd0;
    end
  end
`endif

  // State and read-address registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      addr  <= '0;
    end else begin
      state <= state_next;
      addr  <= addr_next;
    end
  end

  // Next-state, address sequencing and frame-boundary decisions
  always_comb begin
    state_next = state;
    addr_next  = addr;
    latch_cmd  = 1'b0;
    load_xy    = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          addr_next  = '0;
          state_next = S_FETCH;
        end
      end
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_EOF: begin
            frame_done = 1'b1;
            if (loop && !stop) begin
              addr_next  = '0;
              state_next = S_FETCH;
            end else begin
              state_next = S_IDLE;
            end
          end
          OP_NOP: begin
            // A NOP in the last word still closes the frame like an EOF
            if (addr == LAST_ADDR) begin
              frame_done = 1'b1;
              addr_next  = '0;
              state_next = (loop && !stop) ? S_FETCH : S_IDLE;
            end else begin
              addr_next  = addr + 1'b1;
              state_next = S_FETCH;
            end
          end
          default: begin
            latch_cmd  = 1'b1;
            state_next = S_WAIT_RDY;
          end
        endcase
      end
      S_WAIT_RDY: begin
        if (bus.ctrl_ready) begin
          load_xy    = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_GUARD;
      S_GUARD: begin
        // ctrl_ready is still stale for two cycles after the issue
        if (guard_cnt) begin
`ifdef VECSEQ_DWELL_EN
          state_next = op_draw ? S_WAIT_DONE : S_SETTLE;
`else
          state_next = S_WAIT_DONE;
`endif
        end
      end
`ifdef VECSEQ_DWELL_EN
      S_SETTLE: begin
        if (dwell_cnt == DWELL_LAST) begin
          state_next = S_WAIT_DONE;
        end
      end
`endif
      S_WAIT_DONE: begin
        if (bus.ctrl_ready) begin
          if (addr == LAST_ADDR) begin
            frame_done = 1'b1;
            addr_next  = '0;
            state_next = (loop && !stop) ? S_FETCH : S_IDLE;
          end else begin
            addr_next  = addr + 1'b1;
            state_next = stop ? S_IDLE : S_FETCH;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Command latch, visible target coordinates and guard counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_draw   <= 1'b0;
      x_lat     <= 12'd0;
      y_lat     <= 12'd0;
      x_q       <= 12'd0;
      y_q       <= 12'd0;
      guard_cnt <= 1'b0;
    end else begin
      if (latch_cmd) begin
        op_draw <= (opcode == OP_DRAW);
        x_lat   <= bus.mem_data[23:12];
        y_lat   <= bus.mem_data[11:0];
      end
      if (load_xy) begin
        x_q <= x_lat;
        y_q <= y_lat;
      end
      guard_cnt <= (state == S_GUARD) ? ~guard_cnt : 1'b0;
    end
  end

  // Jump opcode is implied by !op_draw; kept for readability of the decode
  logic unused_op_jump;
  assign unused_op_jump = (OP_JUMP == 2'b00);

  assign bus.mem_addr = addr;
  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.jump     = (state == S_ISSUE) && !op_draw;
  assign bus.draw     = (state == S_ISSUE) && op_draw;
  assign bus.beam_on  = op_draw && ((state == S_ISSUE) || (state == S_GUARD) ||
                                    (state == S_WAIT_DONE));
  assign busy         = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vector_list_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vector_list_sequencer                                                  |
// | Self-checking bench: scenario tasks plus randomized display lists checked |
// | against a cycle-count model of the command timing rules.                  |
// | Honours VECSEQ_DWELL_EN for the expected jump cost.                       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_vector_list_sequencer;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;
  localparam int DWELL  = 16;
`ifdef VECSEQ_DWELL_EN
  localparam int DW_EXTRA = DWELL;
`else
  localparam int DW_EXTRA = 0;
`endif
  localparam logic [1:0] OP_JUMP = 2'b00;
  localparam logic [1:0] OP_DRAW = 2'b01;
  localparam logic [1:0] OP_EOF  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic loop = 1'b0;
  logic busy;
  logic frame_done;

  vector_list_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  vector_list_sequencer #(.ADDR_W(ADDR_W), .DWELL(DWELL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop(loop),
    .busy(busy), .frame_done(frame_done), .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Synchronous-read display list
  logic [25:0] mem [DEPTH];
  always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    bit          is_draw;
    logic [11:0] x;
    logic [11:0] y;
  } ev_t;

  ev_t  evq[$];
  ev_t  expq[$];
  int   fdq[$];
  int   n_both = 0;
  int   n_glitch = 0;
  logic [11:0] px = 12'd0;
  logic [11:0] py = 12'd0;
  logic rst_at_edge = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) rst_at_edge <= !reset_n;

  // Observation log: pulses, frame_done cycles, illegal x/y changes
  always @(negedge clk) begin : mon
    ev_t e;
    if (bus.jump || bus.draw) begin
      e.c = cyc; e.is_draw = bus.draw; e.x = bus.x; e.y = bus.y;
      evq.push_back(e);
      if (bus.jump && bus.draw) n_both++;
    end
    if (frame_done) fdq.push_back(cyc);
    if ((bus.x !== px || bus.y !== py) && !(bus.jump || bus.draw) && !rst_at_edge)
      n_glitch++;
    px = bus.x;
    py = bus.y;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, busy=%0b", busy);
    $fatal(1, "watchdog");
  end

  function automatic logic [25:0] mk(input logic [1:0] op, input int xv, input int yv);
    return {op, 12'(xv), 12'(yv)};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(output int cs);
    @(posedge clk);
    #1;
    start = 1'b1;
    cs = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_pulse(input bit want_draw, input int budget, output int tp, output bit to);
    to = 1'b1;
    tp = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((want_draw && bus.draw) || (!want_draw && bus.jump)) begin
        to = 1'b0;
        tp = cyc;
        break;
      end
    end
  endtask

  // Expected frame from the timing rules (ready always 1, loop=0, stop=0):
  // FETCH at cs+1; NOP/EOF decode one cycle after fetch; jump/draw pulse 3
  // cycles after fetch, WAIT_DONE decision 6 cycles after fetch (+dwell for
  // jumps); next fetch one cycle after that decision.
  task automatic model_frame(input int cs, output int fd_c);
    int t;
    int a;
    int wd;
    logic [1:0] op;
    ev_t e;
    t = cs + 1;
    a = 0;
    fd_c = -1;
    expq.delete();
    for (int k = 0; k < DEPTH; k++) begin
      op = mem[a][25:24];
      if (op == OP_EOF) begin
        fd_c = t + 1;
        break;
      end
      if (op == OP_NOP) begin
        if (a == DEPTH - 1) begin
          fd_c = t + 1;
          break;
        end
        t = t + 2;
        a++;
      end else begin
        e.c = t + 3; e.is_draw = (op == OP_DRAW);
        e.x = mem[a][23:12]; e.y = mem[a][11:0];
        expq.push_back(e);
        wd = t + 6 + (e.is_draw ? 0 : DW_EXTRA);
        if (a == DEPTH - 1) begin
          fd_c = wd;
          break;
        end
        t = wd + 1;
        a++;
      end
    end
  endtask

  task automatic test_reset();
    logic [30:0] obs;
    int cs;
    tick();
    obs = {busy, frame_done, bus.jump, bus.draw, bus.beam_on, bus.mem_addr, bus.x, bus.y};
    n_checks++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL reset_held: outputs=%h required 0", obs);
    end
    @(posedge clk); #1; reset_n = 1'b1;
    tick();
    obs = {busy, frame_done, bus.jump, bus.draw, bus.beam_on, bus.mem_addr, bus.x, bus.y};
    n_checks++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL reset_release: outputs=%h required 0", obs);
    end
    stop = 1'b1;
    pulse_start(cs);
    tick(); tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL start_with_stop: busy=%0b required 0", busy);
    end
    stop = 1'b0;
  endtask

  task automatic test_basic();
    int cs, fd;
    bit to;
    mem[0] = mk(OP_JUMP, 100, 200); mem[1] = mk(OP_DRAW, 300, 400);
    mem[2] = mk(OP_EOF, 0, 0);      mem[3] = mk(OP_NOP, 0, 0);
    evq.delete(); fdq.delete();
    pulse_start(cs);
    n_checks++;
    if (bus.mem_addr !== 2'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_fetch: addr=%0d busy=%0b required 0/1", bus.mem_addr, busy);
    end
    model_frame(cs, fd);
    run_until_idle(200, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL basic_timeout: busy=%0b required 0", busy); end
    n_checks++;
    if (evq.size() !== 2) begin
      n_fail++; $display("FAIL basic_count: pulses=%0d required 2", evq.size());
    end else begin
      n_checks++;
      if ({evq[0].c, evq[0].is_draw, evq[0].x, evq[0].y} !== {cs + 4, 1'b0, 12'd100, 12'd200}) begin
        n_fail++; $display("FAIL basic_jump: c=%0d d=%0b x=%0d y=%0d required c=%0d jump 100,200",
                           evq[0].c, evq[0].is_draw, evq[0].x, evq[0].y, cs + 4);
      end
      n_checks++;
      if ({evq[1].c, evq[1].is_draw, evq[1].x, evq[1].y} !== {expq[1].c, 1'b1, 12'd300, 12'd400}) begin
        n_fail++; $display("FAIL basic_draw: c=%0d d=%0b x=%0d y=%0d required c=%0d draw 300,400",
                           evq[1].c, evq[1].is_draw, evq[1].x, evq[1].y, expq[1].c);
      end
    end
    n_checks++;
    if (fdq.size() !== 1 || (fdq.size() == 1 && fdq[0] !== fd)) begin
      n_fail++; $display("FAIL basic_frame_done: count=%0d required 1 at cycle %0d", fdq.size(), fd);
    end
  endtask

  task automatic test_backpressure();
    int cs, td, k, td2, bad_beam, bad_addr, n_ev;
    bit to;
    mem[0] = mk(OP_DRAW, 300, 400); mem[1] = mk(OP_DRAW, 7, 8);
    mem[2] = mk(OP_EOF, 0, 0);      mem[3] = mk(OP_NOP, 0, 0);
    evq.delete(); fdq.delete();
    pulse_start(cs);
    wait_pulse(1'b1, 50, td, to);
    n_checks++;
    if (to || td !== cs + 4) begin
      n_fail++; $display("FAIL bp_first_draw: cycle=%0d required %0d", td, cs + 4);
    end
    @(posedge clk); #1; bus.ctrl_ready = 1'b0;
    bad_beam = 0; bad_addr = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.beam_on !== 1'b1) bad_beam++;
      if (bus.mem_addr !== 2'd0) bad_addr++;
    end
    n_ev = evq.size();
    @(posedge clk); #1; bus.ctrl_ready = 1'b1; k = cyc;
    n_checks++;
    if (bad_beam !== 0) begin n_fail++; $display("FAIL bp_beam_on: low cycles=%0d required 0", bad_beam); end
    n_checks++;
    if (bad_addr !== 0 || n_ev !== 1) begin
      n_fail++; $display("FAIL bp_no_fetch: addr moves=%0d pulses=%0d required 0/1", bad_addr, n_ev);
    end
    wait_pulse(1'b1, 50, td2, to);
    n_checks++;
    if (to || td2 !== k + 4 || bus.x !== 12'd7 || bus.y !== 12'd8) begin
      n_fail++; $display("FAIL bp_resume: cycle=%0d x=%0d y=%0d required %0d 7,8", td2, bus.x, bus.y, k + 4);
    end
    run_until_idle(100, to);
    n_checks++;
    if (to || fdq.size() !== 1) begin
      n_fail++; $display("FAIL bp_end: frames=%0d required 1", fdq.size());
    end
  endtask

  task automatic test_dwell();
    int cs, tj, gap, bad_beam;
    bit to, changed;
    mem[0] = mk(OP_JUMP, 10, 20); mem[1] = mk(OP_DRAW, 30, 40);
    mem[2] = mk(OP_EOF, 0, 0);    mem[3] = mk(OP_NOP, 0, 0);
    evq.delete(); fdq.delete();
    pulse_start(cs);
    wait_pulse(1'b0, 50, tj, to);
    n_checks++;
    if (to || bus.beam_on !== 1'b0) begin
      n_fail++; $display("FAIL dwell_jump: seen=%0b beam_on=%0b required 1/0", !to, bus.beam_on);
    end
    changed = 1'b0; gap = -1; bad_beam = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.mem_addr !== 2'd0) begin
        changed = 1'b1;
        gap = cyc - tj - 1;
        break;
      end
      if (bus.beam_on !== 1'b0) bad_beam++;
    end
    // Cycles strictly between the jump pulse and the first cycle showing
    // the incremented address: GUARD x2, settle, WAIT_DONE.
    n_checks++;
    if (!changed || gap !== 2 + DW_EXTRA + 1) begin
      n_fail++; $display("FAIL dwell_gap: gap=%0d required %0d", gap, 2 + DW_EXTRA + 1);
    end
    n_checks++;
    if (bad_beam !== 0) begin n_fail++; $display("FAIL dwell_blank: beam cycles=%0d required 0", bad_beam); end
    run_until_idle(200, to);
    n_checks++;
    if (to || evq.size() !== 2) begin
      n_fail++; $display("FAIL dwell_end: pulses=%0d required 2", evq.size());
    end
  endtask

  task automatic test_loop();
    int cs, fd, period, td, nfd, bad_addr;
    bit to, prev_fd;
    mem[0] = mk(OP_NOP, 0, 0); mem[1] = mk(OP_DRAW, 5, 5);
    mem[2] = mk(OP_EOF, 0, 0); mem[3] = mk(OP_NOP, 0, 0);
    evq.delete(); fdq.delete();
    loop = 1'b1;
    pulse_start(cs);
    model_frame(cs, fd);
    period = fd - cs;
    to = 1'b1; prev_fd = 1'b0; bad_addr = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (prev_fd && bus.mem_addr !== 2'd0) bad_addr++;
      prev_fd = frame_done;
      if (fdq.size() >= 3 && !frame_done) begin
        to = 1'b0;
        break;
      end
    end
    n_checks++;
    if (to || fdq.size() !== 3) begin
      n_fail++; $display("FAIL loop_frames: count=%0d required 3", fdq.size());
    end else begin
      n_checks++;
      if (fdq[0] !== fd) begin n_fail++; $display("FAIL loop_first: cycle=%0d required %0d", fdq[0], fd); end
      n_checks++;
      if (fdq[1] - fdq[0] !== period || fdq[2] - fdq[1] !== period) begin
        n_fail++; $display("FAIL loop_period: %0d,%0d required %0d", fdq[1] - fdq[0], fdq[2] - fdq[1], period);
      end
    end
    n_checks++;
    if (bad_addr !== 0) begin n_fail++; $display("FAIL loop_addr0: nonzero=%0d required 0", bad_addr); end
    nfd = fdq.size();
    wait_pulse(1'b1, 50, td, to);
    @(posedge clk); #1; stop = 1'b1;
    run_until_idle(100, to);
    n_checks++;
    if (to || cyc !== td + 4) begin
      n_fail++; $display("FAIL loop_stop_idle: idle cycle=%0d required %0d", cyc, td + 4);
    end
    n_checks++;
    if (evq[evq.size() - 1].c !== td || fdq.size() !== nfd || bus.mem_addr !== 2'd2 || bus.beam_on !== 1'b0) begin
      n_fail++; $display("FAIL loop_stop_state: last=%0d frames=%0d addr=%0d beam=%0b required %0d %0d 2 0",
                         evq[evq.size() - 1].c, fdq.size(), bus.mem_addr, bus.beam_on, td, nfd);
    end
    stop = 1'b0;
    loop = 1'b0;
  endtask

  task automatic test_wrap();
    int cs, fd;
    bit to;
    for (int i = 0; i < DEPTH; i++) mem[i] = mk(OP_DRAW, 16 * i + 1, 16 * i + 2);
    evq.delete(); fdq.delete();
    pulse_start(cs);
    model_frame(cs, fd);
    run_until_idle(200, to);
    n_checks++;
    if (to || evq.size() !== 4) begin
      n_fail++; $display("FAIL wrap_draws: pulses=%0d required 4", evq.size());
    end
    n_checks++;
    if (fdq.size() !== 1 || (fdq.size() == 1 && fdq[0] !== fd)) begin
      n_fail++; $display("FAIL wrap_frame_done: count=%0d required 1 at %0d", fdq.size(), fd);
    end
    n_checks++;
    if (bus.mem_addr !== 2'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL wrap_end: addr=%0d busy=%0b required 0/0", bus.mem_addr, busy);
    end
  endtask

  task automatic test_reset_midrun();
    int cs, td;
    bit to;
    logic [30:0] obs;
    mem[0] = mk(OP_DRAW, 11, 22); mem[1] = mk(OP_DRAW, 33, 44);
    mem[2] = mk(OP_EOF, 0, 0);    mem[3] = mk(OP_NOP, 0, 0);
    evq.delete(); fdq.delete();
    pulse_start(cs);
    wait_pulse(1'b1, 50, td, to);
    @(posedge clk); #1; bus.ctrl_ready = 1'b0;
    repeat (5) tick();
    @(posedge clk); #1; reset_n = 1'b0;
    @(posedge clk); #1; reset_n = 1'b1; bus.ctrl_ready = 1'b1;
    obs = {busy, frame_done, bus.jump, bus.draw, bus.beam_on, bus.mem_addr, bus.x, bus.y};
    n_checks++;
    if (to || obs !== '0) begin
      n_fail++; $display("FAIL midrun_reset: outputs=%h required 0", obs);
    end
    evq.delete(); fdq.delete();
    pulse_start(cs);
    n_checks++;
    if (bus.mem_addr !== 2'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL midrun_restart: addr=%0d busy=%0b required 0/1", bus.mem_addr, busy);
    end
    wait_pulse(1'b1, 50, td, to);
    n_checks++;
    if (to || td !== cs + 4 || bus.x !== 12'd11 || bus.y !== 12'd22) begin
      n_fail++; $display("FAIL midrun_first: cycle=%0d x=%0d y=%0d required %0d 11,22", td, bus.x, bus.y, cs + 4);
    end
    run_until_idle(100, to);
  endtask

  task automatic test_random();
    int cs, fd, n;
    bit to;
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] = {2'($urandom_range(0, 3)), 12'($urandom), 12'($urandom)};
      evq.delete(); fdq.delete();
      pulse_start(cs);
      model_frame(cs, fd);
      run_until_idle(300, to);
      n_checks++;
      if (to || cyc !== fd + 1) begin
        n_fail++; $display("FAIL rand%0d_idle: idle cycle=%0d required %0d", r, cyc, fd + 1);
      end
      n_checks++;
      if (fdq.size() !== 1 || (fdq.size() == 1 && fdq[0] !== fd)) begin
        n_fail++; $display("FAIL rand%0d_frame_done: count=%0d required 1 at %0d", r, fdq.size(), fd);
      end
      n_checks++;
      if (evq.size() !== expq.size()) begin
        n_fail++; $display("FAIL rand%0d_count: pulses=%0d required %0d", r, evq.size(), expq.size());
      end
      n = (evq.size() < expq.size()) ? evq.size() : expq.size();
      for (int i = 0; i < n; i++) begin
        n_checks++;
        if ({evq[i].c, evq[i].is_draw, evq[i].x, evq[i].y} !==
            {expq[i].c, expq[i].is_draw, expq[i].x, expq[i].y}) begin
          n_fail++;
          $display("FAIL rand%0d_cmd%0d: c=%0d d=%0b x=%0d y=%0d required c=%0d d=%0b x=%0d y=%0d",
                   r, i, evq[i].c, evq[i].is_draw, evq[i].x, evq[i].y,
                   expq[i].c, expq[i].is_draw, expq[i].x, expq[i].y);
        end
      end
    end
    n_checks++;
    if (n_both !== 0 || n_glitch !== 0) begin
      n_fail++; $display("FAIL pulse_xy_rules: both-high=%0d xy changes=%0d required 0/0", n_both, n_glitch);
    end
  endtask

  initial begin
    bus.ctrl_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = mk(OP_EOF, 0, 0);
    test_reset();
    test_basic();
    test_backpressure();
    test_dwell();
    test_loop();
    test_wrap();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vector_list_sequencer.md
# vector_list_sequencer

Plays a display list of vector commands out of a synchronous-read RAM into the beam controller, one command at a time. Each command is a jump or draw to a 12-bit (x, y) point, a NOP, or an end-of-frame (EOF) marker. The block sits between the display-list memory and the jump/draw/ready interface of the vector controller. It handles fetch, decode, the handshake, post-jump settling, frame looping and beam blanking.

## Interface
Parameters:
- ADDR_W, 10, display-list address width; the list is 2^ADDR_W words.
- DWELL, 16, settle cycles after a jump is accepted. Range 1..255. Used only with VECSEQ_DWELL_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to begin playback at address 0; honoured only in IDLE.
- stop  in  1  level; ends playback at the next fetch boundary.
- loop  in  1  level, sampled at EOF: 1 = replay from address 0, 0 = return to IDLE.
- mem_addr  out  ADDR_W  display-list read address.
- mem_data  in  26  read data, valid the cycle after mem_addr. Fields:
  - [25:24] opcode: 00 jump, 01 draw, 10 EOF, 11 NOP.
  - [23:12] x.
  - [11:0] y.
- x  out  12  target x; held from issue until the next issue.
- y  out  12  target y; held from issue until the next issue.
- jump  out  1  one-cycle jump request to the controller.
- draw  out  1  one-cycle draw request to the controller.
- ctrl_ready  in  1  controller ready for a new command / previous command complete.
- beam_on  out  1  unblank; 1 only while a draw is in progress.
- busy  out  1  1 in every state except IDLE.
- frame_done  out  1  one-cycle pulse per completed frame.

## Operation
States: IDLE, FETCH, DECODE, WAIT_RDY, ISSUE, GUARD, SETTLE, WAIT_DONE.
- IDLE
  - start=1 and stop=0 → mem_addr=0 → FETCH.
  - start with stop=1 is ignored.
- FETCH: mem_addr is stable → DECODE.
- DECODE: mem_data is valid; act on the opcode.
  - NOP: mem_addr+1 → FETCH.
  - EOF: pulse frame_done. If loop=1 and stop=0: mem_addr=0 → FETCH. Otherwise → IDLE.
  - Jump or draw: latch the opcode and coordinates internally → WAIT_RDY.
- WAIT_RDY: wait for ctrl_ready=1 → ISSUE.
- ISSUE (one cycle):
  - Drive x and y from the latched coordinates.
  - Pulse jump or draw.
  - beam_on=0 for a jump, 1 for a draw.
  - → GUARD.
- GUARD: exactly 2 cycles with ctrl_ready ignored, covering the controller's ready-drop latency.
  - After a jump → SETTLE (with macro) or WAIT_DONE (without).
  - After a draw → WAIT_DONE.
- SETTLE: count DWELL cycles with beam_on=0 → WAIT_DONE.
- WAIT_DONE: wait for ctrl_ready=1, then:
  - beam_on=0;
  - mem_addr+1;
  - → FETCH if stop=0, else → IDLE.
- Address wrap: finishing a non-EOF command at address 2^ADDR_W−1 acts as an implicit EOF.
  - mem_addr wraps to 0 and frame_done pulses.
  - loop and stop are then honoured exactly as for a real EOF.
- stop never cuts off a command that has already been issued; that command runs to WAIT_DONE.
- start while busy=1 is ignored.

## Timing
- Reset (reset_n=0 at a clk edge): the next cycle is IDLE with every output 0, including mem_addr, x and y. Reset takes effect from any state.
- start to mem_addr valid: 1 cycle. start to the first jump/draw pulse, with ctrl_ready held at 1: 4 cycles (IDLE→FETCH→DECODE→WAIT_RDY→ISSUE).
- Per-command overhead with ctrl_ready always 1:
  - draw: 6 cycles (FETCH, DECODE, WAIT_RDY, ISSUE, GUARD×2) plus 1 in WAIT_DONE, so 7 cycles per draw;
  - jump: as a draw, plus DWELL cycles when VECSEQ_DWELL_EN is defined;
  - NOP: 2 cycles.
- jump and draw are never high together and never high for more than 1 cycle.
- x and y change only in the ISSUE cycle.
- frame_done is high for the single cycle in which the EOF or wrap decision is made.

## Configuration
- VECSEQ_DWELL_EN defined: the SETTLE state exists. Each accepted jump is followed by DWELL blanked cycles before WAIT_DONE.
- VECSEQ_DWELL_EN undefined:
  - SETTLE is removed and GUARD goes directly to WAIT_DONE for jumps;
  - DWELL is ignored;
  - a jump costs the same cycles as a draw.

## Test plan
- Basic list, ctrl_ready tied to 1, loop=0:
  - list: jump(100,200), draw(300,400), EOF;
  - expect one jump pulse with x=100 and y=200, then one draw pulse with x=300 and y=400;
  - expect one frame_done pulse, then busy=0.
- Backpressure: ctrl_ready=0 for 50 cycles after the draw issue. beam_on stays 1 throughout and no fetch occurs until ctrl_ready returns to 1.
- Dwell with macro defined and DWELL=16: measure from the jump pulse to the next mem_addr increment. Expect exactly 2+16+1 = 19 cycles.
- Loop: loop=1 with list NOP, draw(5,5), EOF. Expect frame_done pulses repeating every frame, with mem_addr returning to 0 each time. Assert stop and expect IDLE after the in-flight draw completes.
- Wrap: ADDR_W=2 with four draw words and no EOF, loop=0. Expect 4 draws, frame_done, mem_addr=0, busy=0.
- Reset in WAIT_DONE of a draw: reset_n=0 for 1 cycle. Expect all outputs 0 the next cycle. A start issued afterwards fetches address 0.
